// File: rtl/judge_scorekeeper.sv
// judge_scorekeeper: turns the per-cycle judgement vector and miss strobe into
// score, combo, max combo, per-tier hit counts and a held on-screen judgement.
// Optional feature macro: JUDGE_SCORE_MULT_EN (combo-based score multiplier).
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   frame_i             one-cycle pulse per video frame (ages the display hold)
//   clear_i             synchronous song restart, clears all state
//   judge_i[3:0]        {marvelous,perfect,great,good}; nonzero = one hit
//   miss_i              an arrow left the screen unjudged
//   score_o             accumulated score (saturating)
//   combo_o             current combo (saturating)
//   max_combo_o         highest combo this song
//   counts_o            {marv,perf,great,good,miss} hit counts, CNTW each
//   disp_o              0 none, 1 good, 2 great, 3 perfect, 4 marvelous, 5 miss
module judge_scorekeeper #(
    parameter int unsigned SCOREW      = 16,
    parameter int unsigned COMBOW      = 10,
    parameter int unsigned CNTW        = 8,
    parameter int unsigned PTS_MARV    = 10,
    parameter int unsigned PTS_PERF    = 8,
    parameter int unsigned PTS_GREAT   = 5,
    parameter int unsigned PTS_GOOD    = 2,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                frame_i,
    input  logic                clear_i,
    input  logic [3:0]          judge_i,
    input  logic                miss_i,
    output logic [SCOREW-1:0]   score_o,
    output logic [COMBOW-1:0]   combo_o,
    output logic [COMBOW-1:0]   max_combo_o,
    output logic [5*CNTW-1:0]   counts_o,
    output logic [2:0]          disp_o
);

    localparam int unsigned SUMW  = SCOREW + 3;
    localparam int unsigned HOLDW = $clog2(HOLD_FRAMES + 1);
    localparam logic [2:0]  DISP_MISS = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_e;

    // Count slots are indexed by display code: 0 miss, 1 good .. 4 marvelous.
    logic [SCOREW-1:0] score_q, score_d;
    logic [COMBOW-1:0] combo_q, combo_d;
    logic [COMBOW-1:0] max_q, max_d;
    logic [CNTW-1:0]   cnt_q [5];
    logic [CNTW-1:0]   cnt_d [5];
    logic [2:0]        disp_q, disp_d;
    logic [HOLDW-1:0]  hold_q, hold_d;
    disp_state_e       state_q, state_d;

    logic              hit_c;
    logic [2:0]        tier_c;
    logic [SUMW-1:0]   pts_c;
    logic [SUMW-1:0]   add_c;
    logic [SUMW-1:0]   sum_c;
    logic [SCOREW-1:0] score_sat_c;
    logic [COMBOW-1:0] combo_inc_c;

    // Priority decode of the winning tier and its base points.
    always_comb begin
        tier_c = 3'd0;
        pts_c  = '0;
        if (judge_i[3]) begin
            tier_c = 3'd4;
            pts_c  = SUMW'(PTS_MARV);
        end else if (judge_i[2]) begin
            tier_c = 3'd3;
            pts_c  = SUMW'(PTS_PERF);
        end else if (judge_i[1]) begin
            tier_c = 3'd2;
            pts_c  = SUMW'(PTS_GREAT);
        end else if (judge_i[0]) begin
            tier_c = 3'd1;
            pts_c  = SUMW'(PTS_GOOD);
        end
    end

    assign hit_c = |judge_i;

`ifdef JUDGE_SCORE_MULT_EN
    // Multiplier comes from the combo before this event: x1, x2, x4.
    logic [1:0] shift_c;
    always_comb begin
        shift_c = 2'd0;
        if (combo_q >= COMBOW'(50)) begin
            shift_c = 2'd2;
        end else if (combo_q >= COMBOW'(10)) begin
            shift_c = 2'd1;
        end
    end
    assign add_c = pts_c << shift_c;
`else
    assign add_c = pts_c;
`endif

    // Wide add, then clamp to the score range.
    assign sum_c       = SUMW'(score_q) + add_c;
    assign score_sat_c = (|sum_c[SUMW-1:SCOREW]) ? '1 : sum_c[SCOREW-1:0];
    assign combo_inc_c = (&combo_q) ? combo_q : combo_q + COMBOW'(1);

    // Next-state for score/combo/counts and the display FSM.
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        disp_d  = disp_q;
        hold_d  = hold_q;
        state_d = state_q;

        if (clear_i) begin
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
            for (int i = 0; i < 5; i++) begin
                cnt_d[i] = '0;
            end
            disp_d  = 3'd0;
            hold_d  = '0;
            state_d = IDLE;
        end else begin
            if (hit_c) begin
                score_d = score_sat_c;
                if (!(&cnt_q[tier_c])) begin
                    cnt_d[tier_c] = cnt_q[tier_c] + CNTW'(1);
                end
                combo_d = combo_inc_c;
                if (combo_inc_c > max_q) begin
                    max_d = combo_inc_c;
                end
            end
            // A same-cycle miss still lets the hit count toward max combo.
            if (miss_i) begin
                if (!(&cnt_q[0])) begin
                    cnt_d[0] = cnt_q[0] + CNTW'(1);
                end
                combo_d = '0;
            end

            if (hit_c || miss_i) begin
                disp_d  = miss_i ? DISP_MISS : tier_c;
                hold_d  = HOLDW'(HOLD_FRAMES);
                state_d = SHOW;
            end else if (state_q == SHOW && frame_i) begin
                if (hold_q == HOLDW'(1)) begin
                    hold_d  = '0;
                    disp_d  = 3'd0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLDW'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
            cnt_q   <= '{default: '0};
            disp_q  <= 3'd0;
            hold_q  <= '0;
            state_q <= IDLE;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            hold_q  <= hold_d;
            state_q <= state_d;
        end
    end

    assign score_o     = score_q;
    assign combo_o     = combo_q;
    assign max_combo_o = max_q;
    assign counts_o    = {cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
    assign disp_o      = disp_q;

endmodule
